pid_loop_sequencer: RTL and testbench

Sequences one pid core instance as a closed control loop.
- Generates the periodic sample tick and captures the plant feedback.
- Slew-limits the setpoint handed to the core.
- Issues the one-cycle trig, waits for done with a timeout, then clamps and publishes the result.
- Sits between the plant ADC/feedback path, the pid core and the actuator/DAC path; replaces hand-driven trig/plant sequencing.

---
 rtl/pid_loop_sequencer.sv | 148 ++++++++++++++
 tb/tb_pid_loop_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_loop_sequencer.sv
// Closed-loop sequencer for a single pid core: sample tick, setpoint slew limiting,
// trigger/done handshake with timeout, and output clamping with sticky error flags.
module pid_loop_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  period,
  input  logic [DATA_WIDTH-1:0] setpoint_in,
  input  logic [DATA_WIDTH-1:0] slew_step,
  input  logic [DATA_WIDTH-1:0] feedback_in,
  input  logic [DATA_WIDTH-1:0] out_min,
  input  logic [DATA_WIDTH-1:0] out_max,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] pid_setpoint,
  output logic [DATA_WIDTH-1:0] pid_feedback,
  output logic                  pid_trig,
  input  logic [DATA_WIDTH-1:0] pid_sig_out,
  input  logic                  pid_done,
  output logic [DATA_WIDTH-1:0] sig_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overrun_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, SAMPLE, TRIG, WAIT_DONE, UPDATE} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [CNT_WIDTH-1:0]   cnt_last;
  logic [TO_W-1:0]        to_cnt_reg;
  logic [DATA_WIDTH-1:0]  sp_cur_reg, sp_next;
  logic [DATA_WIDTH-1:0]  pid_feedback_reg, sig_out_reg, clamped;
  logic                   pid_trig_reg, out_valid_reg, timeout_err_reg, overrun_err_reg;
  logic                   running, tick, to_expired, done_take, timeout_set, overrun_set;
  logic signed [DATA_WIDTH:0] diff, step_ext;

  // A live period compare means a shortened period that the count has already
  // passed only takes effect after the natural counter rollover.
  assign cnt_last   = ((period < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period) - CNT_WIDTH'(1);
  assign running    = enable && (state_reg != IDLE);
  assign tick       = running && (cnt_reg == cnt_last);
  assign busy       = (state_reg == SAMPLE) || (state_reg == TRIG) ||
                      (state_reg == WAIT_DONE) || (state_reg == UPDATE);
  assign to_expired = (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign done_take  = enable && (state_reg == WAIT_DONE) && pid_done;
  assign timeout_set = enable && (state_reg == WAIT_DONE) && !pid_done && to_expired;
  assign overrun_set = tick && busy;

  // Setpoint slew: difference taken one bit wider so it can never wrap.
  always_comb begin
    diff     = $signed({setpoint_in[DATA_WIDTH-1], setpoint_in}) -
               $signed({sp_cur_reg[DATA_WIDTH-1], sp_cur_reg});
    step_ext = $signed({1'b0, slew_step});
    sp_next  = setpoint_in;
    if (slew_step != '0) begin
      if (diff > step_ext)
        sp_next = sp_cur_reg + slew_step;
      else if (diff < -step_ext)
        sp_next = sp_cur_reg - slew_step;
    end
  end

  always_comb begin
    clamped = pid_sig_out;
    if ($signed(pid_sig_out) > $signed(out_max))
      clamped = out_max;
    else if ($signed(pid_sig_out) < $signed(out_min))
      clamped = out_min;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (enable) state_next = WAIT_TICK;
      WAIT_TICK: if (tick) state_next = SAMPLE;
      SAMPLE:    state_next = TRIG;
      TRIG:      state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (pid_done)        state_next = UPDATE;
        else if (to_expired) state_next = WAIT_TICK;
      end
      UPDATE:    state_next = WAIT_TICK;
      default:   state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      to_cnt_reg       <= '0;
      sp_cur_reg       <= '0;
      pid_feedback_reg <= '0;
      sig_out_reg      <= '0;
      pid_trig_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
      timeout_err_reg  <= 1'b0;
      overrun_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (!running || cnt_reg == cnt_last)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);

      if (state_reg == TRIG)
        to_cnt_reg <= '0;
      else if (state_reg == WAIT_DONE && !to_expired)
        to_cnt_reg <= to_cnt_reg + TO_W'(1);

      // Bumpless start: the loop begins regulating to where the plant already is.
      if (enable && state_reg == IDLE)
        sp_cur_reg <= feedback_in;
      if (enable && state_reg == SAMPLE) begin
        sp_cur_reg       <= sp_next;
        pid_feedback_reg <= feedback_in;
      end

      pid_trig_reg  <= enable && (state_reg == SAMPLE);
      out_valid_reg <= done_take;
      if (done_take)
        sig_out_reg <= clamped;

      if (timeout_set)    timeout_err_reg <= 1'b1;
      else if (clear_err) timeout_err_reg <= 1'b0;
      if (overrun_set)    overrun_err_reg <= 1'b1;
      else if (clear_err) overrun_err_reg <= 1'b0;
    end
  end

  assign pid_setpoint = sp_cur_reg;
  assign pid_feedback = pid_feedback_reg;
  assign pid_trig     = pid_trig_reg;
  assign sig_out      = sig_out_reg;
  assign out_valid    = out_valid_reg;
  assign timeout_err  = timeout_err_reg;
  assign overrun_err  = overrun_err_reg;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench for pid_loop_sequencer with a mock pid core that answers a
// programmable number of cycles after each trigger.
module tb_pid_loop_sequencer;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset, enable, clear_err;
  logic [CW-1:0] period;
  logic [DW-1:0] setpoint_in, slew_step, feedback_in, out_min, out_max;
  logic [DW-1:0] pid_setpoint, pid_feedback, sig_out;
  logic [DW-1:0] pid_sig_out = '0;
  logic          pid_done = 1'b0;
  logic          pid_trig, out_valid, busy, timeout_err, overrun_err;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  int                   mock_lat = 3;
  int                   mock_cnt = 0;
  bit                   mock_on = 1'b1;
  bit                   mock_mode = 1'b0;
  logic signed [DW-1:0] mock_val = '0;

  pid_loop_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .setpoint_in(setpoint_in), .slew_step(slew_step), .feedback_in(feedback_in),
    .out_min(out_min), .out_max(out_max), .clear_err(clear_err),
    .pid_setpoint(pid_setpoint), .pid_feedback(pid_feedback), .pid_trig(pid_trig),
    .pid_sig_out(pid_sig_out), .pid_done(pid_done), .sig_out(sig_out),
    .out_valid(out_valid), .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // Mock core: done is sampled by the DUT exactly mock_lat cycles after the trig cycle.
  always @(negedge clk) begin
    pid_done = 1'b0;
    if (pid_trig === 1'b1 && mock_on) begin
      mock_cnt = mock_lat;
    end else if (mock_cnt > 0) begin
      mock_cnt = mock_cnt - 1;
      if (mock_cnt == 0) begin
        pid_done = 1'b1;
        pid_sig_out = mock_mode ? mock_val : ($signed(pid_setpoint) - $signed(pid_feedback));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    if (obs === exp) $display("cyc %0d %s = %0d", cyc, tag, obs);
  endtask

  // sel 0: pid_trig, sel 1: out_valid
  task automatic wait_hi(input int sel, input int budget, input string tag, output int at);
    at = -1;
    for (int n = 0; n < budget && at < 0; n++) begin
      step();
      if ((sel == 0 && pid_trig === 1'b1) || (sel == 1 && out_valid === 1'b1)) at = cyc;
    end
    n_cmp++;
    assert (at >= 0) else begin
      n_fail++;
      $error("FAIL %s: observed=no event expected=event within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int t_en, t1, t2, tv;
    logic seen_err, seen_ov;
    int exp_up[4];
    int exp_dn[3];
    int clamp_in[3];
    int clamp_exp[3];
    exp_up    = '{700, 900, 1000, 1000};
    exp_dn    = '{800, 600, 400};
    clamp_in  = '{5000, -5000, 42};
    clamp_exp = '{100, -100, 42};

    reset = 1'b1; enable = 1'b0; clear_err = 1'b0; period = CW'(12);
    setpoint_in = 10000; slew_step = 0; feedback_in = 0;
    out_min = -100000; out_max = 100000;
    step(); step();
    chk("rst_sig_out", $signed(sig_out), 0);
    chk("rst_pid_trig", pid_trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overrun_err", overrun_err, 0);
    chk("rst_pid_setpoint", $signed(pid_setpoint), 0);
    reset = 1'b0;
    step();

    // Basic loop: period 12, no slew limit, done latency 3
    enable = 1'b1; t_en = cyc;
    wait_hi(0, 40, "first_trig", t1);
    chk("first_trig_latency", t1 - t_en, 14);
    chk("busy_at_trig", busy, 1);
    step();
    chk("trig_one_cycle", pid_trig, 0);
    wait_hi(1, 20, "first_valid", tv);
    chk("valid_after_trig", tv - t1, 4);
    chk("sig_out_basic", $signed(sig_out), 10000);
    step();
    chk("busy_between", busy, 0);
    chk("valid_one_cycle", out_valid, 0);
    wait_hi(0, 20, "second_trig", t2);
    chk("trig_period", t2 - t1, 12);

    // Slew limiting from a bumpless start at the feedback value
    enable = 1'b0;
    step(); step();
    chk("idle_busy", busy, 0);
    feedback_in = 500; setpoint_in = 1000; slew_step = 200;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_hi(0, 40, "slew_up_trig", t1);
      chk($sformatf("slew_up_%0d", k), $signed(pid_setpoint), exp_up[k]);
    end
    chk("sampled_feedback", $signed(pid_feedback), 500);
    setpoint_in = -1000;
    for (int k = 0; k < 3; k++) begin
      wait_hi(0, 40, "slew_dn_trig", t1);
      chk($sformatf("slew_dn_%0d", k), $signed(pid_setpoint), exp_dn[k]);
    end

    // Output clamping, including inverted limits
    out_min = -100; out_max = 100; mock_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mock_val = clamp_in[k];
      wait_hi(1, 40, "clamp_valid", tv);
      chk($sformatf("clamp_%0d", k), $signed(sig_out), clamp_exp[k]);
    end
    out_min = 100; out_max = -100; mock_val = 42;
    wait_hi(1, 40, "inverted_valid", tv);
    chk("clamp_inverted", $signed(sig_out), -100);

    // Timeout: core never answers
    mock_on = 1'b0; out_min = -100000; out_max = 100000;
    wait_hi(0, 40, "to_trig", t1);
    seen_err = 1'b0; seen_ov = 1'b0;
    for (int k = 0; k < TO; k++) begin
      step();
      seen_err |= timeout_err;
      seen_ov |= out_valid;
    end
    chk("timeout_not_early", seen_err, 0);
    step();
    seen_ov |= out_valid;
    chk("timeout_set", timeout_err, 1);
    chk("timeout_no_valid", seen_ov, 0);
    chk("timeout_sig_held", $signed(sig_out), -100);
    wait_hi(0, 40, "retrig", t2);
    chk("retrig_period", t2 - t1, 12);
    clear_err = 1'b1;
    step();
    chk("clear_err", timeout_err, 0);
    for (int k = 0; k < TO; k++) step();
    chk("set_beats_clear", timeout_err, 1);
    clear_err = 1'b0;

    // Overrun with period 4 and done latency 6
    enable = 1'b0;
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("flags_cleared_to", timeout_err, 0);
    chk("flags_cleared_ov", overrun_err, 0);
    mock_on = 1'b1; mock_lat = 6; mock_val = 7; period = CW'(4);
    enable = 1'b1; t_en = cyc;
    wait_hi(0, 40, "ov_trig", t1);
    chk("ov_trig_latency", t1 - t_en, 6);
    step(); step();
    chk("overrun_not_early", overrun_err, 0);
    step();
    chk("overrun_set", overrun_err, 1);
    wait_hi(1, 20, "ov_valid", tv);
    chk("ov_valid_latency", tv - t1, 7);
    chk("ov_sig_out", $signed(sig_out), 7);
    wait_hi(0, 40, "ov_trig2", t2);
    chk("no_trig_while_busy", t2 - t1, 12);
    chk("ov_no_timeout", timeout_err, 0);
    mock_lat = TO;
    wait_hi(0, 40, "edge_trig", t1);
    chk("edge_trig_period", t1 - t2, 12);
    wait_hi(1, 20, "edge_valid", tv);
    chk("done_at_expiry_valid", tv - t1, TO + 1);
    chk("done_at_expiry_no_err", timeout_err, 0);

    // Disruption: enable dropped mid-calculation, then async reset during TRIG
    wait_hi(0, 40, "dis_trig", t1);
    step(); step();
    enable = 1'b0;
    step();
    chk("disable_idle", busy, 0);
    seen_ov = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      seen_ov |= out_valid;
    end
    chk("late_done_ignored", seen_ov, 0);
    chk("disable_sig_held", $signed(sig_out), 7);
    enable = 1'b1;
    wait_hi(0, 40, "rst_trig", t1);
    chk("pre_reset_overrun", overrun_err, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_trig", pid_trig, 0);
    chk("async_rst_sig_out", $signed(sig_out), 0);
    chk("async_rst_overrun", overrun_err, 0);
    chk("async_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
